// File: rtl/bcd_to_binary_seq.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out, BIN_W shift cycles.
// Optional digit check enabled by defining BCD_TO_BINARY_SEQ_DIGIT_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_sh_q, bcd_sh_d;
  logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]   sh_bcd, adj_bcd;
  logic [BIN_W-1:0]   sh_bin;
  logic               bad_digit;

  // One shift step: shift whole register right, then correct digits that landed at >= 8.
  always_comb begin
    {sh_bcd, sh_bin} = {1'b0, bcd_sh_q, bin_sh_q[BIN_W-1:1]};
    adj_bcd = sh_bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8)
        adj_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_sh_d  = bcd_sh_q;
    bin_sh_d  = bin_sh_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
`ifdef BCD_TO_BINARY_SEQ_DIGIT_CHECK_EN
          if (bad_digit) begin
            state_d   = DONE;
            bin_out_d = '0;
            err_d     = 1'b1;
          end else begin
            state_d  = SHIFT;
            bcd_sh_d = bcd_in;
            bin_sh_d = '0;
            cnt_d    = CNT_W'(BIN_W);
          end
`else
          state_d  = SHIFT;
          bcd_sh_d = bcd_in;
          bin_sh_d = '0;
          cnt_d    = CNT_W'(BIN_W);
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_sh_d = adj_bcd;
        bin_sh_d = sh_bin;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bin_out_d = sh_bin;
          err_d     = 1'b0;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_sh_q  <= '0;
      bin_sh_q  <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_sh_q  <= bcd_sh_d;
      bin_sh_q  <= bin_sh_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

`ifdef BCD_TO_BINARY_SEQ_DIGIT_CHECK_EN
  assign err = err_q;
`else
  logic unused_chk;
  assign unused_chk = bad_digit ^ err_q;
  assign err = 1'b0;
`endif
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign bin_out = bin_out_q;

endmodule

// File: doc/bcd_to_binary_seq.md
# bcd_to_binary_seq

Sequential reverse double-dabble converter turning a packed BCD value into unsigned binary. It is the inverse of the slot display's binary-to-BCD path: it converts operator-entered BCD credit and bet values back to binary for the game arithmetic. One conversion runs at a time under a start/busy/done handshake. It takes BIN_W shift cycles per conversion.

## Interface
- DIGITS, 2, number of BCD digits on bcd_in.
- BIN_W, 7, binary result width. Must satisfy 2^BIN_W > 10^DIGITS − 1. The defaults give 99 max, which fits 7 bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request a conversion; sampled on the rising edge.
- bcd_in  input  4*DIGITS  packed BCD operand; digit 0 is bcd_in[3:0]; captured on the accepting edge only.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; bin_out is valid.
- bin_out  output  BIN_W  binary result; held until the next accepted start.
- err  output  1  invalid digit seen. Valid with done and held with bin_out.

## Operation
- Working register: {bcd_sh[4*DIGITS-1:0], bin_sh[BIN_W-1:0]}, plus a shift counter of width clog2(BIN_W+1).
- States:
  - IDLE: waiting for start.
  - SHIFT: running the conversion.
  - DONE: result presented.
- IDLE or DONE with start=1: load bcd_sh←bcd_in, bin_sh←0, counter←BIN_W, and go to SHIFT. A start seen in DONE gives back-to-back operation.
- DONE with start=0: go to IDLE.
- SHIFT, each edge:
  - Shift the whole register right by 1; bcd_sh MSB gets 0.
  - Then, for every digit of the shifted bcd_sh that is ≥8, subtract 3 (mod 16, per digit, with no borrow between digits).
  - Decrement the counter.
  - On the edge where the counter goes 1→0: bin_out←shifted bin_sh, err←0, go to DONE.
- start while in SHIFT is ignored. bcd_in is not re-sampled.
- busy=1 exactly in SHIFT. done=1 exactly in DONE.
- Arithmetic:
  - No overflow is possible for valid input, given the BIN_W constraint.
  - bin_out = Σ digit_k·10^k.
- Reset: state=IDLE; busy=0, done=0, err=0, bin_out=0; working register and counter cleared. This holds also when reset is asserted in SHIFT or DONE, and the interrupted result is discarded.

## Timing
- start accepted at edge N, then:
  - busy=1 from after edge N to after edge N+BIN_W.
  - Shift edges are N+1 … N+BIN_W.
  - done=1 and bin_out valid for the cycle after edge N+BIN_W.
- Latency from start to done: BIN_W cycles (7 with the defaults).
- Throughput: one conversion per BIN_W+1 cycles with back-to-back start (start held in the DONE cycle).
- bin_out and err change only on the edge entering DONE, or on reset.
- Outputs are registered or decoded from state only; there is no combinational path from start or bcd_in.

## Configuration
- Macro: BCD_TO_BINARY_SEQ_DIGIT_CHECK_EN.
- Defined:
  - On the accepting edge, if any digit of bcd_in is >9, skip SHIFT.
  - Go directly to DONE with bin_out←0 and err←1.
  - done is high the cycle after edge N, so the latency is 1.
  - busy is never asserted for that request.
- Not defined:
  - No digit check; err is tied to 0.
  - Every operand, including invalid digits, takes the full BIN_W-cycle SHIFT path.
  - bin_out is whatever the algorithm produces, and the bench checks only timing and err=0.

## Test plan
- **Valid conversions:** bcd_in=8'h99, start 1 cycle → busy for 7 cycles, done pulse 7 cycles after start, bin_out=7'd99, err=0. Repeat with 8'h00 → 0 and 8'h47 → 47.
- **Back-to-back:** 8'h12 then 8'h80, with start held in the DONE cycle → done pulses 8 cycles apart, results 12 and 80, busy low only during the DONE cycles.
- **start while busy:** bcd_in=8'h35 accepted; start and bcd_in=8'h99 applied at cycle 3 → ignored; result 35 at the original done time; returns to IDLE.
- **Reset mid-conversion:** rst pulsed at cycle 4 of converting 8'h63 → busy, done, err, bin_out all 0 immediately; the next start with 8'h21 yields 21 on normal timing.
- **Invalid digit, macro defined:** bcd_in=8'h5A → done 1 cycle after start, err=1, bin_out=0, busy never high.
- **Invalid digit, macro undefined:** bcd_in=8'h5A → done after 7 cycles, err=0.
- **Parameter sweep:** DIGITS=3, BIN_W=10, bcd_in=12'h999 → bin_out=999 after 10 cycles; 12'h100 → 100.
